// File: rtl/gsau_wb_buffer_pkg.sv
// Shared vector types and writeback-buffer entry layout for the GSAU
// writeback path.
package gsau_wb_buffer_pkg;

  localparam int unsigned VREG_W   = 512;
  localparam int unsigned VSEL_W   = 5;
  localparam int unsigned WB_DEPTH = 4;

  typedef logic [VREG_W-1:0] vreg_t;
  typedef logic [VSEL_W-1:0] vsel_t;

  typedef struct packed {
    vsel_t dst;
    vreg_t data;
  } wb_entry_t;

endpackage

// File: rtl/gsau_wb_buffer_if.sv
// Upstream GSAU -> writeback buffer handshake (psum + destination register).
interface gsau_wb_buffer_if;
  import gsau_wb_buffer_pkg::*;

  vreg_t wb_psum;
  vsel_t wb_wbdst;
  logic  wb_valid;
  logic  wb_output_ready;

  modport master (
    output wb_psum,
    output wb_wbdst,
    output wb_valid,
    input  wb_output_ready
  );

  modport slave (
    input  wb_psum,
    input  wb_wbdst,
    input  wb_valid,
    output wb_output_ready
  );

endinterface

// File: rtl/gsau_wb_buffer_wb_fifo.sv
// Circular FIFO of writeback entries; exposes every slot and its valid bit so
// the parent can run a hazard compare across the whole buffer.
module gsau_wb_buffer_wb_fifo
  import gsau_wb_buffer_pkg::*;
#(
  parameter  int unsigned DEPTH = WB_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  wb_entry_t        push_data_i,
  input  logic             pop_i,
  output wb_entry_t        head_o,
  output wb_entry_t        entries_o [DEPTH],
  output logic [DEPTH-1:0] valid_o,
  output logic [PTR_W:0]   count_o,
  output logic             full_o,
  output logic             empty_o
);

  wb_entry_t        mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // DEPTH is a power of two, so pointer increments wrap naturally.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    valid_d = valid_q;
    if (do_push) begin
      valid_d[wptr_q] = 1'b1;
      wptr_d          = wptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      valid_d[rptr_q] = 1'b0;
      rptr_d          = rptr_q + PTR_W'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + (PTR_W+1)'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= push_data_i;
    end
  end

  assign head_o    = mem_q[rptr_q];
  assign entries_o = mem_q;
  assign valid_o   = valid_q;
  assign count_o   = count_q;

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= (PTR_W+1)'(DEPTH));

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop_i && empty_o));

endmodule

// File: rtl/gsau_wb_buffer.sv
// In-order writeback buffer between the GSAU control unit and the veggie
// register file, with scoreboard commit notify and pending-write hazard query.
module gsau_wb_buffer
  import gsau_wb_buffer_pkg::*;
#(
  parameter  int unsigned DEPTH = WB_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic            CLK,
  input  logic            nRST,
  gsau_wb_buffer_if.slave wb,
  output logic            veg_wen,
  output vsel_t           veg_wdst,
  output vreg_t           veg_wdata,
  input  logic            veg_wready,
  output logic            sb_wb_done,
  output vsel_t           sb_wb_dst,
  input  vsel_t           hz_vsel,
  output logic            hz_pending,
  output logic [PTR_W:0]  occupancy,
  output logic            empty
);

  wb_entry_t        push_entry;
  wb_entry_t        head;
  wb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PTR_W:0]   count;
  logic             full, fifo_empty, commit;
  logic             sb_done_q, sb_done_d;
  vsel_t            sb_dst_q, sb_dst_d;

  assign push_entry = '{dst: wb.wb_wbdst, data: wb.wb_psum};

  gsau_wb_buffer_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (CLK),
    .rst_n       (nRST),
    .push_i      (wb.wb_valid),
    .push_data_i (push_entry),
    .pop_i       (commit),
    .head_o      (head),
    .entries_o   (entries),
    .valid_o     (valid),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (fifo_empty)
  );

  // Ready comes only from the registered count, never from veg_wready.
  assign wb.wb_output_ready = !full;

  assign veg_wen   = !fifo_empty;
  assign commit    = veg_wen && veg_wready;
  // Head slot is uninitialised storage when empty; present zeros instead.
  assign veg_wdst  = veg_wen ? head.dst  : '0;
  assign veg_wdata = veg_wen ? head.data : '0;

  always_comb begin
    sb_done_d = commit;
    sb_dst_d  = commit ? head.dst : sb_dst_q;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sb_done_q <= 1'b0;
      sb_dst_q  <= '0;
    end else begin
      sb_done_q <= sb_done_d;
      sb_dst_q  <= sb_dst_d;
    end
  end

  assign sb_wb_done = sb_done_q;
  assign sb_wb_dst  = sb_dst_q;

  always_comb begin
    hz_pending = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[i] && (entries[i].dst == hz_vsel)) begin
        hz_pending = 1'b1;
      end
    end
  end

  assign occupancy = count;
  assign empty     = fifo_empty;

  a_wb_hold_stable: assert property (@(posedge CLK) disable iff (!nRST)
    (wb.wb_valid && !wb.wb_output_ready) |=>
      (wb.wb_valid && $stable(wb.wb_psum) && $stable(wb.wb_wbdst)));

endmodule

// File: tb/tb_gsau_wb_buffer.sv
// Directed bench for gsau_wb_buffer with a commit-order scoreboard.
module tb_gsau_wb_buffer;
  import gsau_wb_buffer_pkg::*;

  localparam int unsigned DEPTH = WB_DEPTH;
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic           clk = 1'b0;
  logic           nRST = 1'b0;
  logic           veg_wen;
  vsel_t          veg_wdst;
  vreg_t          veg_wdata;
  logic           veg_wready = 1'b0;
  logic           sb_wb_done;
  vsel_t          sb_wb_dst;
  vsel_t          hz_vsel = '0;
  logic           hz_pending;
  logic [PTR_W:0] occupancy;
  logic           empty;

  int n_cmp = 0;
  int n_mis = 0;

  wb_entry_t exp_q[$];
  wb_entry_t mon_e;
  logic      prev_commit = 1'b0;
  logic      prev_stall  = 1'b0;
  vsel_t     exp_sb_dst  = '0;
  vsel_t     held_dst;
  vreg_t     held_data;

  gsau_wb_buffer_if wbif ();

  gsau_wb_buffer #(
    .DEPTH (DEPTH)
  ) dut (
    .CLK        (clk),
    .nRST       (nRST),
    .wb         (wbif),
    .veg_wen    (veg_wen),
    .veg_wdst   (veg_wdst),
    .veg_wdata  (veg_wdata),
    .veg_wready (veg_wready),
    .sb_wb_done (sb_wb_done),
    .sb_wb_dst  (sb_wb_dst),
    .hz_vsel    (hz_vsel),
    .hz_pending (hz_pending),
    .occupancy  (occupancy),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic vreg_t mk_data(input int unsigned s);
    vreg_t d;
    for (int unsigned k = 0; k < 16; k++) d[k*32 +: 32] = s * 32'h9E37_79B9 + k;
    return d;
  endfunction

  function automatic logic hz_model(input vsel_t v);
    foreach (exp_q[k]) if (exp_q[k].dst == v) return 1'b1;
    return 1'b0;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic push(input vsel_t dst, input vreg_t data);
    int unsigned n;
    bit done;
    n = 0;
    done = 0;
    wbif.wb_valid = 1'b1;
    wbif.wb_wbdst = dst;
    wbif.wb_psum  = data;
    while (!done) begin
      @(negedge clk);
      if (wbif.wb_output_ready) begin
        exp_q.push_back('{dst: dst, data: data});
        done = 1;
      end
      @(posedge clk);
      #1;
      n++;
      if (!done && n >= 64) begin
        chk("push_timeout", 512'(wbif.wb_output_ready), 512'(1));
        done = 1;
      end
    end
    wbif.wb_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && empty) break;
      @(posedge clk);
      #1;
    end
    chk({tag, "_empty"}, 512'(empty), 512'(1));
    chk({tag, "_occ"}, 512'(occupancy), 512'(0));
  endtask

  // Commit monitor: a commit at the coming edge is visible at the negedge before it.
  always @(negedge clk) begin
    if (!nRST) begin
      prev_commit = 1'b0;
      prev_stall  = 1'b0;
      exp_sb_dst  = '0;
    end else begin
      chk("sb_done", 512'(sb_wb_done), 512'(prev_commit));
      chk("sb_dst", 512'(sb_wb_dst), 512'(exp_sb_dst));
      if (prev_stall) begin
        chk("stall_dst", 512'(veg_wdst), 512'(held_dst));
        chk("stall_data", veg_wdata, held_data);
      end
      prev_commit = veg_wen && veg_wready;
      prev_stall  = veg_wen && !veg_wready;
      held_dst    = veg_wdst;
      held_data   = veg_wdata;
      if (prev_commit) begin
        chk("commit_expected", 512'(exp_q.size() != 0), 512'(1));
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("commit_dst", 512'(veg_wdst), 512'(mon_e.dst));
          chk("commit_data", veg_wdata, mon_e.data);
          exp_sb_dst = mon_e.dst;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vsel_t hz_list [3];
    hz_list[0] = 5'd7;
    hz_list[1] = 5'd9;
    hz_list[2] = 5'd5;
    wbif.wb_valid = 1'b0;
    wbif.wb_wbdst = '0;
    wbif.wb_psum  = '0;

    // Reset values
    #2;
    chk("rst_veg_wen", 512'(veg_wen), 512'(0));
    chk("rst_veg_wdst", 512'(veg_wdst), 512'(0));
    chk("rst_veg_wdata", veg_wdata, 512'(0));
    chk("rst_sb_done", 512'(sb_wb_done), 512'(0));
    chk("rst_sb_dst", 512'(sb_wb_dst), 512'(0));
    chk("rst_hz", 512'(hz_pending), 512'(0));
    chk("rst_occ", 512'(occupancy), 512'(0));
    chk("rst_empty", 512'(empty), 512'(1));
    chk("rst_ready", 512'(wbif.wb_output_ready), 512'(1));
    repeat (2) @(posedge clk);
    #1;
    nRST = 1'b1;

    // 1: single entry, minimum latency
    veg_wready = 1'b1;
    push(5'd3, {64{8'hA5}});
    chk("t1_wen", 512'(veg_wen), 512'(1));
    chk("t1_occ", 512'(occupancy), 512'(1));
    chk("t1_wdst", 512'(veg_wdst), 512'(3));
    @(posedge clk);
    #1;
    chk("t1_empty", 512'(empty), 512'(1));
    chk("t1_sb_done", 512'(sb_wb_done), 512'(1));
    chk("t1_sb_dst", 512'(sb_wb_dst), 512'(3));
    @(posedge clk);
    #1;
    chk("t1_sb_done_low", 512'(sb_wb_done), 512'(0));
    chk("t1_sb_dst_hold", 512'(sb_wb_dst), 512'(3));

    // 2: fill while stalled, fifth producer waits, release drains in order
    veg_wready = 1'b0;
    for (int unsigned d = 1; d <= 4; d++) push(vsel_t'(d), mk_data(d));
    chk("t2_ready_full", 512'(wbif.wb_output_ready), 512'(0));
    chk("t2_occ_full", 512'(occupancy), 512'(4));
    fork
      push(5'd5, mk_data(5));
      begin
        @(posedge clk);
        #1;
        chk("t2_stalled_ready", 512'(wbif.wb_output_ready), 512'(0));
        chk("t2_stalled_occ", 512'(occupancy), 512'(4));
        veg_wready = 1'b1;
        @(posedge clk);
        #1;
        chk("t2_after_commit_occ", 512'(occupancy), 512'(3));
        chk("t2_after_commit_ready", 512'(wbif.wb_output_ready), 512'(1));
        @(posedge clk);
        #1;
        chk("t2_fifth_in_occ", 512'(occupancy), 512'(3));
      end
    join
    wait_drain("t2");

    // 3: full-rate stream, twenty entries
    for (int unsigned i = 0; i < 20; i++) begin
      push(vsel_t'(i % 32), mk_data(100 + i));
      chk("t3_occ", 512'(occupancy), 512'(1));
      if (i > 0) chk("t3_sb_done", 512'(sb_wb_done), 512'(1));
    end
    wait_drain("t3");

    // 4: hazard query
    veg_wready = 1'b0;
    push(5'd7, mk_data(200));
    push(5'd7, mk_data(201));
    push(5'd9, mk_data(202));
    hz_vsel = 5'd7;
    #1 chk("t4_hz7", 512'(hz_pending), 512'(1));
    hz_vsel = 5'd9;
    #1 chk("t4_hz9", 512'(hz_pending), 512'(1));
    hz_vsel = 5'd5;
    #1 chk("t4_hz5", 512'(hz_pending), 512'(0));
    @(posedge clk);
    #1;
    veg_wready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      for (int unsigned v = 0; v < 3; v++) begin
        hz_vsel = hz_list[v];
        #0.5;
        chk("t4_hz_model", 512'(hz_pending), 512'(hz_model(hz_list[v])));
      end
      if (c == 1) begin
        hz_vsel = 5'd7;
        #0.5 chk("t4_hz7_cleared", 512'(hz_pending), 512'(0));
        hz_vsel = 5'd9;
        #0.5 chk("t4_hz9_still", 512'(hz_pending), 512'(1));
      end
    end
    wait_drain("t4");

    // 5: random back-pressure on the veggie port
    veg_wready = 1'b0;
    for (int unsigned d = 10; d < 14; d++) push(vsel_t'(d), mk_data(300 + d));
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      veg_wready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    veg_wready = 1'b1;
    wait_drain("t5");

    // 6: asynchronous reset mid-cycle with entries queued
    veg_wready = 1'b0;
    push(5'd20, mk_data(400));
    push(5'd21, mk_data(401));
    push(5'd22, mk_data(402));
    chk("t6_wen_pre", 512'(veg_wen), 512'(1));
    chk("t6_occ_pre", 512'(occupancy), 512'(3));
    #1;
    nRST = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_wen", 512'(veg_wen), 512'(0));
    chk("t6_sb_done", 512'(sb_wb_done), 512'(0));
    chk("t6_occ", 512'(occupancy), 512'(0));
    chk("t6_ready", 512'(wbif.wb_output_ready), 512'(1));
    chk("t6_empty", 512'(empty), 512'(1));
    chk("t6_hz", 512'(hz_pending), 512'(0));
    @(negedge clk);
    @(posedge clk);
    #3;
    nRST = 1'b1;
    veg_wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("t6_no_stale", 512'(veg_wen), 512'(0));
    end
    push(5'd25, mk_data(500));
    chk("t6_post_wen", 512'(veg_wen), 512'(1));
    wait_drain("t6");

    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/gsau_wb_buffer.md
Name: gsau_wb_buffer

Overview:
In-order writeback buffer directly downstream of the GSAU control unit.
- Accepts partial-sum results (psum plus destination vector register) over the wb_* valid/ready handshake.
- Queues them in a small FIFO and drains them into the vector register file (veggie file) write port.
- Reports each committed writeback to the scoreboard, and answers a pending-write hazard query for any vector register.

Parameters:
DEPTH, 4, number of buffered entries; power of two, at least 2.
PTR_W, $clog2(DEPTH), read/write pointer width; derived, not overridden.

Ports:
CLK  input  1  system clock, rising edge
nRST  input  1  asynchronous active-low reset
wb_psum  input  512 (vreg_t)  partial-sum data from GSAU
wb_wbdst  input  5 (vsel_t)  destination vector register from GSAU
wb_valid  input  1  GSAU output valid
wb_output_ready  output  1  buffer can accept an entry this cycle
veg_wen  output  1  write request to veggie file (valid)
veg_wdst  output  5 (vsel_t)  write destination register
veg_wdata  output  512 (vreg_t)  write data
veg_wready  input  1  veggie write port granted this cycle
sb_wb_done  output  1  one-cycle pulse: a writeback committed
sb_wb_dst  output  5 (vsel_t)  register committed (valid with sb_wb_done)
hz_vsel  input  5 (vsel_t)  register being queried by the scoreboard
hz_pending  output  1  some buffered entry targets hz_vsel
occupancy  output  PTR_W+1  current entry count
empty  output  1  occupancy == 0

Behaviour:
Reset:
- nRST low clears pointers and count, and drops all entries, including reset mid-drain.
- Every output resets to 0 except wb_output_ready=1 and empty=1.

Storage: DEPTH entries of wb_entry_t {dst, data}, circular; pointers wrap from DEPTH-1 to 0.

Enqueue:
- Occurs when wb_valid && wb_output_ready; entry written at wptr, wptr++.
- wb_output_ready = !full, registered-count based. No combinational path from veg_wready.

Dequeue:
- veg_wen = !empty; veg_wdst/veg_wdata = head entry.
- Commit when veg_wen && veg_wready; rptr++.
- While veg_wen is high and veg_wready is low, veg_wdst/veg_wdata hold stable.

Simultaneous enqueue and commit: occupancy unchanged; both pointers advance.

Full: wb_output_ready=0. A commit while full frees a slot, but ready rises only on the next cycle.

Empty: no bypass. An entry accepted at edge N raises veg_wen after edge N, so earliest commit is edge N+1 (minimum latency 1 cycle).

Order: strictly FIFO. Two entries to the same vsel commit in arrival order.

Scoreboard notify:
- sb_wb_done and sb_wb_dst are registered.
- Pulse in the cycle after the commit edge, for exactly one cycle per commit.
- Back-to-back commits give back-to-back pulses.
- sb_wb_dst holds its last value when sb_wb_done is 0.

Hazard:
- hz_pending is combinational OR over valid entries of (entry.dst == hz_vsel).
- An entry committing at edge N no longer counts after edge N.
- An entry accepted at edge N counts from after edge N.

Occupancy/empty are registered, not predictive.

Protocol checks (simulation assertions):
- wb_valid high with wb_output_ready low must hold wb_psum/wb_wbdst stable until accepted.
- Count never exceeds DEPTH or underflows.

Decomposition:
vector_pkg: vreg_t (512b) and vsel_t (5b) already live there; add WB_DEPTH=4 and typedef struct packed wb_entry_t {vsel_t dst; vreg_t data;}.

gsau_control_unit_if: the wb_buffer modport covers the upstream side.

Sub-module wb_fifo:
- Parameterised circular FIFO of wb_entry_t exposing entries and valid bits for the hazard compare.
- The top level adds the veggie handshake, scoreboard notify and hz logic.

Test Plan:
1. Reset, then one push (dst=3, data=all 0xA5), veg_wready=1 -> veg_wen high the cycle after accept; committed 1 cycle later; sb_wb_done pulses one cycle with sb_wb_dst=3; empty returns to 1.
2. Hold veg_wready=0 and push 4 entries dst=1,2,3,4 -> wb_output_ready=0 after 4th accept, occupancy=4. A 5th wb_valid held stalls. Release veg_wready -> commits in order 1,2,3,4, 5th accepted the cycle after the first commit.
3. Continuous push and pop at full rate for 20 entries (dst=i%32) -> occupancy stable at 1, no drops; pointer wrap exercised 5 times; sb_wb_done high every cycle of the stream.
4. Buffer holds dst=7 twice and dst=9; hz_vsel=7 -> hz_pending=1. After both dst=7 commits -> 0. hz_vsel=9 -> 1 until its commit edge, then 0. hz_vsel=5 -> 0 throughout.
5. veg_wready toggled 0/1 randomly with stalled head -> veg_wdst/veg_wdata never change while veg_wen&&!veg_wready.
6. Assert nRST low (asynchronously, mid-cycle) with 3 entries queued and veg_wen high -> immediately veg_wen=0, sb_wb_done=0, occupancy=0, wb_output_ready=1. After release, no stale entry is ever written.
